comp_seq: RTL and testbench

- Parametrised, multi-cycle magnitude comparator with start/done handshake.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock.
- Cascadable through EQ0/GT0 from a more-significant stage; supports unsigned or two's-complement signed compare.
- Feeds ALU branch/condition logic where a wide single-cycle comparator would limit timing.

---
 rtl/comp_pkg.sv | 26 ++
 rtl/comp_seq_if.sv | 27 ++
 rtl/comp_chunk.sv | 22 ++
 rtl/comp_seq.sv | 118 +++++++++++
 tb/tb_comp_seq.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/comp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Holds the FSM state encoding, the counter-sizing helper and the default chunk width.
package comp_pkg;

   localparam int DEF_CHUNK = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Ceiling log2, used to size the chunk counter.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/comp_seq_if.sv
// Request/response bundle of comp_seq: operands, mode and cascade inputs in,
// handshake and three-way result out.
interface comp_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             signed_mode;
   logic             EQ0;
   logic             GT0;
   logic             busy;
   logic             done;
   logic             EQ1;
   logic             GT1;
   logic             LT1;

   modport master (
      output start, A, B, signed_mode, EQ0, GT0,
      input  busy, done, EQ1, GT1, LT1
   );

   modport slave (
      input  start, A, B, signed_mode, EQ0, GT0,
      output busy, done, EQ1, GT1, LT1
   );
endinterface

// File: rtl/comp_chunk.sv
// Combinational cascade cell: folds one CHUNK-bit slice into a running eq/gt verdict.
// The first differing slice (from the MSB side) decides; later slices cannot override it.
module comp_chunk
   import comp_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             eq_in,
   input  logic             gt_in,
   output logic             eq_out,
   output logic             gt_out
);

   logic w_diff;

   assign w_diff = (a != b);
   assign eq_out = eq_in & ~w_diff;
   assign gt_out = (eq_in & w_diff) ? (a > b) : gt_in;

endmodule

// File: rtl/comp_seq.sv
// Multi-cycle cascadable magnitude comparator, CHUNK bits per clock, MSB chunk first.
// Define COMP_EARLY_EXIT_EN to finish as soon as the verdict is known (results unchanged).
module comp_seq
   import comp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic       clock,
   input  logic       reset,
   comp_seq_if.slave  bus
);

   localparam int             NCH  = WIDTH / CHUNK;
   localparam int             CW   = (clog2(NCH) < 1) ? 1 : clog2(NCH);
   localparam logic [CW-1:0]  LAST = CW'(NCH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_eq;
   logic             r_gt;
   logic [CW-1:0]    r_cnt;
   logic             r_eq1;
   logic             r_gt1;
   logic             r_lt1;

   logic             w_accept;
   logic             w_last;
   logic             w_exit;
   logic             w_eq_out;
   logic             w_gt_out;
   logic [WIDTH-1:0] w_sign_flip;

   assign w_accept    = bus.start & (r_state != RUN);
   // Flipping both MSBs maps two's-complement order onto unsigned order.
   assign w_sign_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};

   // Operands shift left each RUN edge, so the active chunk is always the top slice.
   comp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a      (r_a[WIDTH-1 -: CHUNK]),
      .b      (r_b[WIDTH-1 -: CHUNK]),
      .eq_in  (r_eq),
      .gt_in  (r_gt),
      .eq_out (w_eq_out),
      .gt_out (w_gt_out)
   );

   assign w_last = (r_cnt == LAST);
`ifdef COMP_EARLY_EXIT_EN
   assign w_exit = w_last | ~w_eq_out;
`else
   assign w_exit = w_last;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // NOTE: default assignment first, so no path through this block leaves w_next unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = RUN;
         RUN:     if (w_exit)    w_next = FIN;
         FIN:     w_next = bus.start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (r_state == RUN);
      bus.done = (r_state == FIN);
   end

   // NOTE: operand registers carry no reset; they are always loaded before being consumed.
   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_a <= bus.A ^ w_sign_flip;
         r_b <= bus.B ^ w_sign_flip;
      end else if (r_state == RUN) begin
         r_a <= r_a << CHUNK;
         r_b <= r_b << CHUNK;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_eq  <= 1'b0;
         r_gt  <= 1'b0;
         r_cnt <= '0;
         r_eq1 <= 1'b0;
         r_gt1 <= 1'b0;
         r_lt1 <= 1'b0;
      end else if (w_accept) begin
         r_eq  <= bus.EQ0;
         r_gt  <= bus.GT0;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_eq  <= w_eq_out;
         r_gt  <= w_gt_out;
         r_cnt <= r_cnt + 1'b1;
         if (w_exit) begin
            r_eq1 <= w_eq_out;
            r_gt1 <= ~w_eq_out & w_gt_out;
            r_lt1 <= ~w_eq_out & ~w_gt_out;
         end
      end
   end

   assign bus.EQ1 = r_eq1;
   assign bus.GT1 = r_gt1;
   assign bus.LT1 = r_lt1;

endmodule

// File: tb/tb_comp_seq.sv
// Directed self-checking bench for comp_seq at WIDTH=8, CHUNK=2.
// Expected latencies follow COMP_EARLY_EXIT_EN; expected results are identical either way.
module tb_comp_seq;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   localparam logic [2:0] R_EQ = 3'b100;
   localparam logic [2:0] R_GT = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;
`ifdef COMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   always #5 clock = ~clock;

   comp_seq_if #(.WIDTH(8)) bif ();

   comp_seq #(.WIDTH(8), .CHUNK(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   function automatic int lat(input int early);
      return EE ? early : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] res();
      return {bif.EQ1, bif.GT1, bif.LT1};
   endfunction

   // Counts edges from the current point until done is seen at a negedge (bounded).
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clock);
         n++;
         @(negedge clock);
      end while (bif.done !== 1'b1 && n < 20);
   endtask

   task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic eq0, input logic gt0,
                          input logic [2:0] exp_res, input int exp_lat);
      int n;
      @(negedge clock);
      bif.A = a; bif.B = b; bif.signed_mode = sm; bif.EQ0 = eq0; bif.GT0 = gt0;
      bif.start = 1'b1;
      @(posedge clock);
      #1 bif.start = 1'b0;
      @(negedge clock);
      check({tag, "_busy"}, bif.busy, 1'b1);
      wait_done(n);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_res"}, res(), exp_res);
      check({tag, "_busy_at_done"}, bif.busy, 1'b0);
      @(negedge clock);
      check({tag, "_done_fall"}, bif.done, 1'b0);
      check({tag, "_hold"}, res(), exp_res);
   endtask

   initial begin
      int n;
      int seen;
      reset = 1'b1;
      bif.start = 1'b0; bif.A = '0; bif.B = '0;
      bif.signed_mode = 1'b0; bif.EQ0 = 1'b1; bif.GT0 = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_state", {bif.busy, bif.done, bif.EQ1, bif.GT1, bif.LT1}, 5'b0);
      reset = 1'b0;

      run_cmp("a5_eq", 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, R_EQ, 4);

      // Random traffic, then reset two cycles in: everything including results clears.
      @(negedge clock);
      bif.A = 8'($urandom); bif.B = 8'($urandom); bif.start = 1'b1;
      @(posedge clock);
      #1 bif.start = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("reset_after_traffic", {bif.busy, bif.done, bif.EQ1, bif.GT1, bif.LT1}, 5'b0);
      reset = 1'b0;

      run_cmp("80_7f_u",   8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, R_GT, lat(1));
      run_cmp("80_7f_s",   8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, R_LT, lat(1));
      run_cmp("3c_casc_gt", 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, R_GT, lat(1));
      run_cmp("3c_casc_lt", 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, R_LT, lat(1));
      run_cmp("3c_eq_gt0", 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b1, R_EQ, 4);
      run_cmp("c0_40_u",   8'hC0, 8'h40, 1'b0, 1'b1, 1'b0, R_GT, lat(1));
      run_cmp("c0_40_s",   8'hC0, 8'h40, 1'b1, 1'b1, 1'b0, R_LT, lat(1));
      run_cmp("12_13_u",   8'h12, 8'h13, 1'b0, 1'b1, 1'b0, R_LT, 4);
      run_cmp("7f_80_s",   8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, R_GT, lat(1));
      run_cmp("fe_ff_s",   8'hFE, 8'hFF, 1'b1, 1'b1, 1'b0, R_LT, 4);
      run_cmp("24_14_u",   8'h24, 8'h14, 1'b0, 1'b1, 1'b0, R_GT, lat(2));

      // start while busy is ignored; the original 10 vs 20 compare completes.
      @(negedge clock);
      bif.A = 8'h10; bif.B = 8'h20; bif.signed_mode = 1'b0; bif.EQ0 = 1'b1; bif.GT0 = 1'b0;
      bif.start = 1'b1;
      @(posedge clock);
      #1 bif.start = 1'b0;
      @(negedge clock);
      bif.A = 8'hFF; bif.B = 8'h00; bif.start = 1'b1;
      @(posedge clock);
      #1 bif.start = 1'b0;
      wait_done(n);
      check("busy_ignore_lat", n + 1, lat(2));
      check("busy_ignore_res", res(), R_LT);

      // Reset sampled on RUN edge 2 aborts with no done pulse.
      @(negedge clock);
      bif.A = 8'hA5; bif.B = 8'hA5; bif.start = 1'b1;
      @(posedge clock);
      #1 bif.start = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("abort_idle", {bif.busy, bif.done}, 2'b00);
      seen = 0;
      repeat (8) begin
         @(negedge clock);
         if (bif.done === 1'b1) seen++;
      end
      check("abort_no_done", seen, 0);
      run_cmp("after_abort", 8'h24, 8'h14, 1'b0, 1'b1, 1'b0, R_GT, lat(2));

      // start held through FIN gives back-to-back done pulses 5 cycles apart.
      @(negedge clock);
      bif.A = 8'h12; bif.B = 8'h13; bif.signed_mode = 1'b0; bif.EQ0 = 1'b1;
      bif.start = 1'b1;
      @(posedge clock);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bif.done !== 1'b1 && n < 20);
      check("b2b_first_res", res(), R_LT);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bif.done !== 1'b1 && n < 20);
      bif.start = 1'b0;
      check("b2b_gap", n, 5);
      check("b2b_second_res", res(), R_LT);
      @(negedge clock);
      check("b2b_idle", {bif.busy, bif.done}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
